mux8_scan_ctrl: RTL and testbench

Sequential serializer stage that drives an 8:1 multiplexer datapath. It accepts an 8-bit word over a valid/ready handshake, holds it on the mux data inputs, and steps the 3-bit select through all eight positions. It samples the mux output each cycle and presents the result as a framed serial bit stream. It sits directly upstream of the 8x1 mux, driving `i[7:0]` and `s[2:0]`, and also consumes the mux's `y`.

---
 rtl/mux8_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_mux8_scan_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_scan_ctrl.sv
// Serializer that loads a byte onto an 8:1 mux, walks the select through all
// eight positions and turns the sampled mux output into a framed bit stream.
module mux8_scan_ctrl #(
    parameter int MSB_FIRST  = 0,
    parameter int GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       abort,
    output logic [7:0] mux_i,
    output logic [2:0] mux_s,
    input  logic       mux_y,
    output logic       ser_bit,
    output logic       ser_valid,
    output logic       ser_first,
    output logic       ser_last,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Stepping by 7 modulo 8 is the same as counting down.
    localparam logic [2:0] SEL_START = (MSB_FIRST != 0) ? 3'd7 : 3'd0;
    localparam logic [2:0] SEL_STEP  = (MSB_FIRST != 0) ? 3'd7 : 3'd1;
    localparam logic [3:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    logic [1:0] state_q, state_d;
    logic [7:0] mux_i_q, mux_i_d;
    logic [2:0] mux_s_q, mux_s_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [3:0] gap_q, gap_d;
    logic       ser_bit_q, ser_bit_d;
    logic       ser_valid_q, ser_valid_d;
    logic       ser_first_q, ser_first_d;
    logic       ser_last_q, ser_last_d;

    // Handshake: a word transfers on a rising edge where in_valid and in_ready
    // are both high and abort is low; in_ready depends on state only.
    assign in_ready  = (state_q == ST_IDLE);
    assign mux_i     = mux_i_q;
    assign mux_s     = mux_s_q;
    assign ser_bit   = ser_bit_q;
    assign ser_valid = ser_valid_q;
    assign ser_first = ser_first_q;
    assign ser_last  = ser_last_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        mux_i_d     = mux_i_q;
        mux_s_d     = mux_s_q;
        bitcnt_d    = bitcnt_q;
        gap_d       = gap_q;
        ser_bit_d   = ser_bit_q;
        ser_valid_d = 1'b0;
        ser_first_d = 1'b0;
        ser_last_d  = 1'b0;

        if (abort) begin
            state_d  = ST_IDLE;
            bitcnt_d = 3'd0;
            mux_s_d  = SEL_START;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        mux_i_d  = in_data;
                        mux_s_d  = SEL_START;
                        bitcnt_d = 3'd0;
                        state_d  = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    ser_bit_d   = mux_y;
                    ser_valid_d = 1'b1;
                    ser_first_d = (bitcnt_q == 3'd0);
                    ser_last_d  = (bitcnt_q == 3'd7);
                    bitcnt_d    = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        mux_s_d = SEL_START;
                        if (GAP_CYCLES > 0) begin
                            state_d = ST_GAP;
                            gap_d   = GAP_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        mux_s_d = mux_s_q + SEL_STEP;
                    end
                end
                ST_GAP: begin
                    if (gap_q == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_d = gap_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mux_i_q     <= 8'h00;
            mux_s_q     <= SEL_START;
            bitcnt_q    <= 3'd0;
            gap_q       <= 4'd0;
            ser_bit_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mux_i_q     <= mux_i_d;
            mux_s_q     <= mux_s_d;
            bitcnt_q    <= bitcnt_d;
            gap_q       <= gap_d;
            ser_bit_q   <= ser_bit_d;
            ser_valid_q <= ser_valid_d;
            ser_first_q <= ser_first_d;
            ser_last_q  <= ser_last_d;
        end
    end

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Bench for mux8_scan_ctrl: three instances (LSB-first, MSB-first, 3-cycle gap)
// each driving a real 8:1 mux, checked cycle by cycle against a word-age model.
`timescale 1ns/1ps
module tb_mux8_scan_ctrl;

    localparam int N = 3;

    logic       clk;
    logic       rst_n;
    logic       iv [N];
    logic [7:0] id [N];
    logic       ab [N];
    logic       ir [N];
    logic [7:0] mi [N];
    logic [2:0] ms [N];
    logic       my [N];
    logic       sb [N];
    logic       sv [N];
    logic       sf [N];
    logic       sl [N];
    logic [1:0] st [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        mux8_scan_ctrl #(
            .MSB_FIRST  ((g == 1) ? 1 : 0),
            .GAP_CYCLES ((g == 2) ? 3 : 0)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_data   (id[g]),
            .in_ready  (ir[g]),
            .abort     (ab[g]),
            .mux_i     (mi[g]),
            .mux_s     (ms[g]),
            .mux_y     (my[g]),
            .ser_bit   (sb[g]),
            .ser_valid (sv[g]),
            .ser_first (sf[g]),
            .ser_last  (sl[g]),
            .dbg_state (st[g])
        );
        assign my[g] = mi[g][ms[g]];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: each instance tracks the age (edges since accept) of its word.
    int         m_age  [N];
    logic [7:0] m_word [N];
    logic [7:0] m_mi   [N];
    logic       e_sv [N];
    logic       e_sf [N];
    logic       e_sl [N];
    logic       e_sb [N];
    logic       e_ir [N];
    logic [2:0] e_ms [N];
    int         e_pos [N];
    logic [7:0] obs_w [N];
    logic       dut_acc [N];
    int         acc_last [N];
    int         acc_prev [N];
    logic [9:0] exp_q [$];
    int         n_checks;
    int         n_fail;
    int         cyc;

    function automatic int cfg_msb(input int g);
        return (g == 1) ? 1 : 0;
    endfunction

    function automatic int cfg_gap(input int g);
        return (g == 2) ? 3 : 0;
    endfunction

    function automatic logic [2:0] start_sel(input int g);
        return (cfg_msb(g) != 0) ? 3'd7 : 3'd0;
    endfunction

    task automatic check(input string tag, input int g, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s[%0d] cycle %0d: observed %0h expected %0h", tag, g, cyc, obs, expv);
        end
    endtask

    function automatic int find_word(input int g);
        int idx;
        idx = -1;
        foreach (exp_q[i]) begin
            if (idx < 0 && exp_q[i][9:8] == 2'(g)) idx = i;
        end
        return idx;
    endfunction

    task automatic score(input int g);
        int idx;
        logic found;
        idx = find_word(g);
        found = (idx >= 0);
        check("sb_entry", g, 8'(found), 8'd1);
        if (found) begin
            check("sb_word", g, obs_w[g], exp_q[idx][7:0]);
            exp_q.delete(idx);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < N; g++) begin
            m_age[g] = -1;
            m_mi[g]  = 8'h00;
            e_sv[g]  = 1'b0;
            e_sf[g]  = 1'b0;
            e_sl[g]  = 1'b0;
            e_sb[g]  = 1'b0;
            e_ir[g]  = 1'b1;
            e_ms[g]  = start_sel(g);
            e_pos[g] = 0;
            obs_w[g] = 8'h00;
        end
        exp_q.delete();
    endtask

    task automatic model_edge();
        for (int g = 0; g < N; g++) begin
            int k;
            int idx;
            e_sv[g] = 1'b0;
            e_sf[g] = 1'b0;
            e_sl[g] = 1'b0;
            if (ab[g]) begin
                if (m_age[g] >= 0 && m_age[g] < 8) begin
                    idx = find_word(g);
                    if (idx >= 0) exp_q.delete(idx);
                end
                m_age[g] = -1;
            end else if (m_age[g] < 0) begin
                if (iv[g]) begin
                    m_age[g]  = 0;
                    m_word[g] = id[g];
                    m_mi[g]   = id[g];
                    exp_q.push_back({2'(g), id[g]});
                end
            end else begin
                m_age[g]++;
                if (m_age[g] <= 8) begin
                    k        = m_age[g] - 1;
                    e_pos[g] = (cfg_msb(g) != 0) ? 7 - k : k;
                    e_sv[g]  = 1'b1;
                    e_sb[g]  = m_word[g][e_pos[g]];
                    e_sf[g]  = (k == 0);
                    e_sl[g]  = (k == 7);
                end
                if (m_age[g] >= 8 + cfg_gap(g)) m_age[g] = -1;
            end
            e_ir[g] = (m_age[g] < 0);
            if (m_age[g] >= 1 && m_age[g] <= 7)
                e_ms[g] = (cfg_msb(g) != 0) ? 3'(7 - m_age[g]) : 3'(m_age[g]);
            else
                e_ms[g] = start_sel(g);
        end
    endtask

    task automatic check_all(input logic with_sb);
        for (int g = 0; g < N; g++) begin
            check("ser_valid", g, 8'(sv[g]), 8'(e_sv[g]));
            check("ser_first", g, 8'(sf[g]), 8'(e_sf[g]));
            check("ser_last",  g, 8'(sl[g]), 8'(e_sl[g]));
            check("in_ready",  g, 8'(ir[g]), 8'(e_ir[g]));
            check("mux_s",     g, 8'(ms[g]), 8'(e_ms[g]));
            check("mux_i",     g, mi[g], m_mi[g]);
            if (e_sv[g] || with_sb) check("ser_bit", g, 8'(sb[g]), 8'(e_sb[g]));
            if (e_sv[g]) begin
                obs_w[g][e_pos[g]] = sb[g];
                if (e_sl[g]) score(g);
            end
        end
    endtask

    task automatic step();
        for (int g = 0; g < N; g++) dut_acc[g] = ir[g] && iv[g] && !ab[g];
        @(posedge clk);
        cyc++;
        model_edge();
        for (int g = 0; g < N; g++) begin
            if (dut_acc[g]) begin
                acc_prev[g] = acc_last[g];
                acc_last[g] = cyc;
            end
        end
        #1;
        check_all(1'b0);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        for (int g = 0; g < N; g++) begin
            iv[g] = 1'b0;
            id[g] = 8'h00;
            ab[g] = 1'b0;
            acc_last[g] = 0;
            acc_prev[g] = 0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        model_reset();
        check_all(1'b1);
        #8 rst_n = 1'b1;

        // LSB-first word A5 with in_valid held through the word
        id[0] = 8'hA5; iv[0] = 1'b1;
        run(9);
        iv[0] = 1'b0;
        run(2);

        // MSB-first back-to-back words 81 then 3C
        id[1] = 8'h81; iv[1] = 1'b1;
        step();
        id[1] = 8'h3C;
        run(9);
        iv[1] = 1'b0;
        check("b2b_spacing", 1, 8'(acc_last[1] - acc_prev[1]), 8'd9);
        run(10);

        // Three-cycle gap between two held words
        id[2] = 8'hC3; iv[2] = 1'b1;
        step();
        id[2] = 8'h96;
        run(12);
        iv[2] = 1'b0;
        check("gap_spacing", 2, 8'(acc_last[2] - acc_prev[2]), 8'd12);
        run(14);

        // Abort after the third serial bit, then abort colliding with a new offer
        id[0] = 8'hFF; iv[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        run(3);
        ab[0] = 1'b1;
        step();
        id[0] = 8'h0F; iv[0] = 1'b1;
        step();
        ab[0] = 1'b0;
        step();
        iv[0] = 1'b0;
        run(10);

        // Asynchronous reset in the middle of a word
        id[1] = 8'h5A; iv[1] = 1'b1;
        step();
        iv[1] = 1'b0;
        run(3);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(1'b1);
        #2 rst_n = 1'b1;
        id[1] = 8'h5A; iv[1] = 1'b1;
        step();
        iv[1] = 1'b0;
        run(10);

        // Offers while busy are ignored; the held word goes in on the first ready cycle
        id[2] = 8'h11; iv[2] = 1'b1;
        step();
        repeat (6) begin
            iv[2] = 1'($urandom_range(0, 1));
            id[2] = 8'($urandom);
            step();
        end
        id[2] = 8'hE7; iv[2] = 1'b1;
        run(6);
        iv[2] = 1'b0;
        check("ready_accept", 2, 8'(acc_last[2] - acc_prev[2]), 8'd12);
        run(14);

        // Random traffic with occasional aborts on all three instances
        for (int c = 0; c < 400; c++) begin
            for (int g = 0; g < N; g++) begin
                if (!iv[g] || m_age[g] == 0) begin
                    iv[g] = ($urandom_range(0, 2) != 0);
                    id[g] = 8'($urandom);
                end
                ab[g] = ($urandom_range(0, 39) == 0);
            end
            step();
        end
        for (int g = 0; g < N; g++) begin
            iv[g] = 1'b0;
            ab[g] = 1'b0;
        end
        run(16);
        check("sb_empty", 0, 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
